uart_tx_arbiter: RTL

//  Shares one UART transmitter (8-bit byte in, start pulse, busy out) among NUM_REQ byte producers.

---
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ==========================================================================
// uart_tx_arbiter_if : producer/transmitter bundle around uart_tx_arbiter.
// Rev 1.0
// ==========================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [2:0]           grant_id;
  logic                 active;
  logic                 err_timeout;

  // Arbiter side
  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );

  // Producers + transmitter side
  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ==========================================================================
// uart_tx_arbiter : round-robin sharing of one UART transmitter among NUM_REQ
// producers. Optional TX-start watchdog: define UART_ARB_WDOG_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  wire logic          clk,
  input  wire logic          reset,
  uart_tx_arbiter_if.master  arb_if
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  data_q, data_d;

  logic [7:0]  valid_pad;
  logic [63:0] data_pad;
  logic [3:0]  cand;
  logic        win_found;
  logic [2:0]  win_idx;
  logic        wdog_expire;

  // Padding to the 8-requester maximum keeps all index widths fixed.
  assign valid_pad = 8'(arb_if.req_valid);
  assign data_pad  = 64'(arb_if.req_data);

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!win_found && valid_pad[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

`ifdef UART_ARB_WDOG_EN
  localparam int CNT_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [CNT_W-1:0] wdog_q, wdog_d;

  assign wdog_expire = (state_q == S_WAIT_BUSY) && !arb_if.tx_busy &&
                       (wdog_q == CNT_W'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_LAUNCH) begin
      wdog_d = '0;
    end else if (state_q == S_WAIT_BUSY) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_expire = 1'b0;

  // WDOG_CYCLES only sizes the watchdog; referenced here so the plain build stays clean.
  if (WDOG_CYCLES < 2) begin : g_wdog_unused
  end
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !arb_if.tx_busy) begin
          data_d   = data_pad[{win_idx, 3'b000} +: 8];
          grant_d  = win_idx;
          rr_ptr_d = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (arb_if.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wdog_expire) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!arb_if.tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 3'd0;
      grant_q  <= 3'd0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign arb_if.req_ready[i] = (state_q == S_LAUNCH) && (grant_q == 3'(i));
  end

  assign arb_if.tx_start    = (state_q == S_LAUNCH);
  assign arb_if.tx_data     = data_q;
  assign arb_if.grant_id    = grant_q;
  assign arb_if.active      = (state_q != S_IDLE);
  assign arb_if.err_timeout = wdog_expire;

endmodule

`default_nettype wire
